// File: rtl/div_sqrt_iter_unit_pkg.sv
// Shared definitions for the iterative divide / square-root unit.
package fpu_defs_div_sqrt_tp;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_SQRT = 1'b1;

endpackage

// File: rtl/div_sqrt_iter_unit_step.sv
// One radix-2 non-restoring step shared by divide and square root.
// Remainder sign selects add/subtract; subtraction is done as add of the
// inverted term with a carry-in. Disabled steps pass their inputs through.
module div_sqrt_step
  import fpu_defs_div_sqrt_tp::*;
#(
  parameter int unsigned C_QW = 10,
  parameter int unsigned C_RW = 15,
  parameter int unsigned C_DW = 9
) (
  input  logic            en,
  input  logic            op,
  input  logic [1:0]      rad_bits,
  input  logic [C_DW-1:0] divisor,
  input  logic [C_RW-1:0] rem_in,
  input  logic [C_QW-1:0] root_in,
  output logic [C_RW-1:0] rem_out,
  output logic [C_QW-1:0] root_out
);

  logic            sub;
  logic [C_RW-1:0] shifted;
  logic [C_RW-1:0] term;
  logic [C_RW-1:0] operand;
  logic [C_RW-1:0] sum;

  // Shift remainder, pick divisor or {root,digit,1} term, then add/subtract.
  always_comb begin
    sub     = ~rem_in[C_RW-1];
    shifted = {rem_in[C_RW-2:0], 1'b0};
    term    = C_RW'(divisor);
    if (op == OP_SQRT) begin
      shifted = {rem_in[C_RW-3:0], rad_bits};
      term    = C_RW'({root_in, ~sub, 1'b1});
    end
    operand = sub ? ~term : term;
    sum     = shifted + operand + C_RW'(sub);
    rem_out  = rem_in;
    root_out = root_in;
    if (en) begin
      rem_out  = sum;
      root_out = {root_in[C_QW-2:0], ~sum[C_RW-1]};
    end
  end

endmodule

// File: rtl/div_sqrt_iter_unit.sv
// Iterative mantissa divider / square-root unit with fixed latency.
// C_UNROLL chained radix-2 steps per cycle; final remainder is restored
// before the sticky bit is taken.
module div_sqrt_iter_unit
  import fpu_defs_div_sqrt_tp::*;
#(
  parameter int unsigned C_WIDTH  = 53,
  parameter int unsigned C_UNROLL = 1
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_SI,
  input  logic                 In_valid_SI,
  output logic                 In_ready_SO,
  input  logic                 Op_SI,
  input  logic                 Sqrt_odd_SI,
  input  logic [C_WIDTH-1:0]   Mant_a_DI,
  input  logic [C_WIDTH-1:0]   Mant_b_DI,
  input  logic                 Kill_SI,
  output logic                 Out_valid_SO,
  input  logic                 Out_ready_SI,
  output logic [C_WIDTH+1:0]   Result_DO,
  output logic                 Sticky_SO,
  output logic                 Div_zero_SO
);

  localparam int unsigned W  = C_WIDTH;
  localparam int unsigned QW = W + 2;
  localparam int unsigned N  = (QW + C_UNROLL - 1) / C_UNROLL;
  localparam int unsigned RW = QW + 5;
  localparam int unsigned DW = W + 1;
  localparam int unsigned XW = 2 * QW;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            op_q;
  logic            div_zero_q;
  logic [DW-1:0]   divisor_q;
  logic [XW-1:0]   rad_q;
  logic [RW-1:0]   rem_q;
  logic [QW-1:0]   root_q;
  logic [QW-1:0]   result_q;
  logic            sticky_q;
  logic            dz_out_q;

  logic            last_c;
  logic            accept_c;
  logic            finish_c;
  logic [RW-1:0]   rem_f;
  logic [QW-1:0]   root_f;
  logic [RW-1:0]   corr_term;
  logic [RW-1:0]   rem_fix;

  assign last_c       = (cnt_q == CW'(N - 1));
  assign In_ready_SO  = (state_q == IDLE) | ((state_q == DONE) & Out_ready_SI);
  assign Out_valid_SO = (state_q == DONE);
  assign Result_DO    = result_q;
  assign Sticky_SO    = sticky_q;
  assign Div_zero_SO  = dz_out_q;

  // Step chain; steps past QW total in the last cycle are masked.
  for (genvar j = 0; j < C_UNROLL; j++) begin : g_step
    logic          en;
    logic [RW-1:0] rem_i, rem_o;
    logic [QW-1:0] root_i, root_o;
    if (j == 0) begin : g_first
      assign rem_i  = rem_q;
      assign root_i = root_q;
    end else begin : g_next
      assign rem_i  = g_step[j-1].rem_o;
      assign root_i = g_step[j-1].root_o;
    end
    assign en = ((32'(cnt_q) * C_UNROLL) + 32'(j)) < QW;
    div_sqrt_step #(.C_QW(QW), .C_RW(RW), .C_DW(DW)) u_step (
      .en       (en),
      .op       (op_q),
      .rad_bits (rad_q[XW-1-2*j -: 2]),
      .divisor  (divisor_q),
      .rem_in   (rem_i),
      .root_in  (root_i),
      .rem_out  (rem_o),
      .root_out (root_o)
    );
  end

  assign rem_f  = g_step[C_UNROLL-1].rem_o;
  assign root_f = g_step[C_UNROLL-1].root_o;

  // Restore a negative final remainder so sticky reflects the true remainder.
  always_comb begin
    corr_term = RW'(divisor_q);
    if (op_q == OP_SQRT) begin
      corr_term = RW'({root_f, 1'b1});
    end
    rem_fix = rem_f;
    if (rem_f[RW-1]) begin
      rem_fix = rem_f + corr_term;
    end
  end

  // State register.
  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes; kill outranks accept outside IDLE.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (In_valid_SI) begin
          accept_c = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (Kill_SI) begin
          state_d = IDLE;
        end else if (last_c) begin
          finish_c = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (Kill_SI) begin
          state_d = IDLE;
        end else if (Out_ready_SI) begin
          if (In_valid_SI) begin
            accept_c = 1'b1;
            state_d  = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result registers.
  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      cnt_q      <= '0;
      op_q       <= OP_DIV;
      div_zero_q <= 1'b0;
      divisor_q  <= '0;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      result_q   <= '0;
      sticky_q   <= 1'b0;
      dz_out_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        cnt_q      <= '0;
        op_q       <= Op_SI;
        div_zero_q <= (Op_SI == OP_DIV) & ~Mant_b_DI[W-1];
        divisor_q  <= {Mant_b_DI, 1'b0};
        rad_q      <= Sqrt_odd_SI ? (XW'(Mant_a_DI) << (XW - W))
                                  : (XW'(Mant_a_DI) << (XW - W - 1));
        rem_q      <= (Op_SI == OP_SQRT) ? '0 : RW'(Mant_a_DI);
        root_q     <= '0;
      end else if (state_q == BUSY) begin
        cnt_q  <= last_c ? '0 : cnt_q + CW'(1);
        rem_q  <= rem_f;
        root_q <= root_f;
        rad_q  <= rad_q << (2 * C_UNROLL);
      end
      if (finish_c) begin
        result_q <= div_zero_q ? '1 : root_f;
        sticky_q <= div_zero_q ? 1'b0 : (|rem_fix);
        dz_out_q <= div_zero_q;
      end
    end
  end

endmodule

// File: tb/tb_div_sqrt_iter_unit.sv
// Scoreboard bench for div_sqrt_iter_unit at W=8, C_UNROLL=2 (QW=10, N=5).
module tb_div_sqrt_iter_unit;

  localparam int W  = 8;
  localparam int QW = 10;
  localparam int N  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          op = 1'b0;
  logic          sqrt_odd = 1'b0;
  logic [W-1:0]  mant_a = '0;
  logic [W-1:0]  mant_b = '0;
  logic          kill = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [QW-1:0] result;
  logic          sticky;
  logic          div_zero;

  typedef struct {
    logic [QW-1:0] res;
    logic          st;
    logic          dz;
    int            acc;
  } exp_t;

  typedef struct {
    logic          op;
    logic          odd;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [QW-1:0] r;
    logic          s;
    logic          d;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  div_sqrt_iter_unit #(.C_WIDTH(W), .C_UNROLL(2)) dut (
    .Clk_CI       (clk),
    .Rst_SI       (rst),
    .In_valid_SI  (in_valid),
    .In_ready_SO  (in_ready),
    .Op_SI        (op),
    .Sqrt_odd_SI  (sqrt_odd),
    .Mant_a_DI    (mant_a),
    .Mant_b_DI    (mant_b),
    .Kill_SI      (kill),
    .Out_valid_SO (out_valid),
    .Out_ready_SI (out_ready),
    .Result_DO    (result),
    .Sticky_SO    (sticky),
    .Div_zero_SO  (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one operation, wait for acceptance and record the expectation.
  task automatic issue(input logic o, input logic odd, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [QW-1:0] er,
                       input logic es, input logic ed, input logic k);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; sqrt_odd = odd; mant_a = a; mant_b = b; kill = k;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", in_ready, 1);
    e.res = er; e.st = es; e.dz = ed; e.acc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    mant_a = W'($urandom); mant_b = W'($urandom);
    op = 1'($urandom); sqrt_odd = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Monitor: latency on first valid cycle, data on each handshake.
  bit   pending = 1'b0;
  exp_t m;
  always @(negedge clk) begin
    if (!out_valid) begin
      pending = 1'b0;
    end else begin
      if (!pending) begin
        pending = 1'b1;
        if (sb.size() == 0) chk("unexpected_valid", out_valid, 0);
        else                chk("latency", cyc - sb[0].acc - 1, N);
      end
      if (out_ready && sb.size() != 0) begin
        m = sb.pop_front();
        chk("result", result, m.res);
        chk("sticky", sticky, m.st);
        chk("div_zero", div_zero, m.dz);
        pending = 1'b0;
      end
    end
  end

  vec_t vecs[11] = '{
    '{1'b0, 1'b0, 8'h80, 8'h80, 10'h200, 1'b0, 1'b0},
    '{1'b0, 1'b0, 8'hC0, 8'h80, 10'h300, 1'b0, 1'b0},
    '{1'b0, 1'b0, 8'h80, 8'hC0, 10'h155, 1'b1, 1'b0},
    '{1'b1, 1'b0, 8'h80, 8'h3C, 10'h200, 1'b0, 1'b0},
    '{1'b1, 1'b1, 8'h80, 8'h00, 10'h2D4, 1'b1, 1'b0},
    '{1'b0, 1'b0, 8'h80, 8'h40, 10'h3FF, 1'b0, 1'b1},
    '{1'b1, 1'b0, 8'hC0, 8'h00, 10'h273, 1'b1, 1'b0},
    '{1'b0, 1'b0, 8'hFF, 8'h80, 10'h3FC, 1'b0, 1'b0},
    '{1'b0, 1'b0, 8'h80, 8'hFF, 10'h101, 1'b1, 1'b0},
    '{1'b1, 1'b1, 8'hFF, 8'h00, 10'h3FD, 1'b1, 1'b0},
    '{1'b0, 1'b0, 8'hC0, 8'h00, 10'h3FF, 1'b0, 1'b1}
  };

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_ready", in_ready, 1);

    // Directed vectors, issued back to back.
    foreach (vecs[i]) issue(vecs[i].op, vecs[i].odd, vecs[i].a, vecs[i].b,
                            vecs[i].r, vecs[i].s, vecs[i].d, 1'b0);
    drain();

    // Kill asserted while idle must not block the accept.
    issue(1'b0, 1'b0, 8'hC0, 8'h80, 10'h300, 1'b0, 1'b0, 1'b1);
    drain();

    // Kill in the third busy cycle.
    issue(1'b0, 1'b0, 8'h80, 8'hC0, 10'h155, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1; kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("kill_ready", in_ready, 1);
    repeat (8) begin
      chk("kill_no_valid", out_valid, 0);
      @(negedge clk);
    end

    // Reset in the middle of an operation.
    issue(1'b1, 1'b1, 8'h80, 8'h00, 10'h2D4, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_sticky", sticky, 0);
    chk("mid_rst_div_zero", div_zero, 0);
    chk("mid_rst_ready", in_ready, 1);
    repeat (8) @(negedge clk);
    chk("mid_rst_no_valid", out_valid, 0);

    // Stall in DONE for four cycles, then release with a new op (back-to-back).
    @(posedge clk); #1; out_ready = 1'b0;
    issue(1'b0, 1'b0, 8'h80, 8'hC0, 10'h155, 1'b1, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_result", result, 10'h155);
      chk("stall_sticky", sticky, 1);
      chk("stall_ready", in_ready, 0);
      if (i < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; op = 1'b1; sqrt_odd = 1'b1; mant_a = 8'h80; mant_b = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_ready", in_ready, 1);
    begin
      exp_t e;
      e.res = 10'h2D4; e.st = 1'b1; e.dz = 1'b0; e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    mant_a = 8'h11;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", fails);
    $fatal(1, "watchdog");
  end

endmodule
